// File: rtl/rs_rr_arbiter_if.sv
// Valid/ready bundle between NUM_CH requesters and one output stream.
// slave = arbiter side, master = requester/consumer side.
interface rs_rr_arbiter_if #(
    parameter int DATA_WIDTH = 512,
    parameter int NUM_CH     = 4
);
    localparam int CH_W = $clog2(NUM_CH);

    logic [NUM_CH-1:0]            s_tvalid;
    logic [NUM_CH*DATA_WIDTH-1:0] s_tdata;
    logic [NUM_CH-1:0]            s_tlast;
    logic [NUM_CH-1:0]            s_tready;
    logic                         m_tvalid;
    logic [DATA_WIDTH-1:0]        m_tdata;
    logic                         m_tlast;
    logic [CH_W-1:0]              m_tid;
    logic                         m_tready;

    modport slave (
        input  s_tvalid, s_tdata, s_tlast, m_tready,
        output s_tready, m_tvalid, m_tdata, m_tlast, m_tid
    );

    modport master (
        output s_tvalid, s_tdata, s_tlast, m_tready,
        input  s_tready, m_tvalid, m_tdata, m_tlast, m_tid
    );
endinterface

// File: rtl/rs_rr_arbiter.sv
// Packet-atomic round-robin N:1 arbiter feeding a 2-entry output buffer.
// m_tready only affects the buffer; s_tready depends on buffer space alone.
module rs_rr_arbiter #(
    parameter int DATA_WIDTH = 512,
    parameter int NUM_CH     = 4
) (
    input  logic           user_clk,
    input  logic           reset_n,
    rs_rr_arbiter_if.slave bus,
    output logic           busy
);
    localparam int CH_W = $clog2(NUM_CH);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [CH_W-1:0]       cur_grant_q, cur_grant_d;
    logic [CH_W-1:0]       last_grant_q, last_grant_d;
    logic [1:0]            cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] data0_q, data0_d, data1_q, data1_d;
    logic                  last0_q, last0_d, last1_q, last1_d;
    logic [CH_W-1:0]       id0_q, id0_d, id1_q, id1_d;

    logic                  found;
    logic [CH_W-1:0]       cand;
    logic [CH_W-1:0]       sel;
    logic                  space;
    logic                  rdy;
    logic                  acc;
    logic                  deq;
    logic                  wr1;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_last;
    logic [NUM_CH-1:0]     s_tready_c;

    // Round-robin candidate search starting just after the last granted channel
    always_comb begin
        found = 1'b0;
        cand  = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            if (!found &&
                bus.s_tvalid[CH_W'((int'(last_grant_q) + k) % NUM_CH)]) begin
                found = 1'b1;
                cand  = CH_W'((int'(last_grant_q) + k) % NUM_CH);
            end
        end
    end

    // Select the serviced channel and raise its ready when the buffer has room
    always_comb begin
        space      = (cnt_q != 2'd2);
        sel        = (state_q == LOCKED) ? cur_grant_q : cand;
        rdy        = space && ((state_q == LOCKED) || found);
        acc        = rdy && bus.s_tvalid[sel];
        in_data    = bus.s_tdata[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
        in_last    = bus.s_tlast[sel];
        s_tready_c = '0;
        if (rdy) begin
            s_tready_c[sel] = 1'b1;
        end
    end

    // Grant FSM: a non-last beat locks the grant until the tlast beat
    always_comb begin
        state_d      = state_q;
        cur_grant_d  = cur_grant_q;
        last_grant_d = last_grant_q;
        if (acc) begin
            cur_grant_d = sel;
            if (in_last) begin
                state_d      = IDLE;
                last_grant_d = sel;
            end else begin
                state_d = LOCKED;
            end
        end
    end

    // Two-entry FIFO: entry 0 is the head shown on m_*, entry 1 the skid slot
    always_comb begin
        deq     = (cnt_q != 2'd0) && bus.m_tready;
        wr1     = acc && (cnt_q == 2'd1) && !deq;
        data0_d = data0_q;
        last0_d = last0_q;
        id0_d   = id0_q;
        data1_d = data1_q;
        last1_d = last1_q;
        id1_d   = id1_q;
        if (deq) begin
            data0_d = data1_q;
            last0_d = last1_q;
            id0_d   = id1_q;
        end
        if (wr1) begin
            data1_d = in_data;
            last1_d = in_last;
            id1_d   = sel;
        end else if (acc) begin
            data0_d = in_data;
            last0_d = in_last;
            id0_d   = sel;
        end
        cnt_d = cnt_q + {1'b0, acc} - {1'b0, deq};
    end

    // Control state registers
    always_ff @(posedge user_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cur_grant_q  <= '0;
            last_grant_q <= CH_W'(NUM_CH - 1);
            cnt_q        <= 2'd0;
        end else begin
            state_q      <= state_d;
            cur_grant_q  <= cur_grant_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
        end
    end

    // Buffer payload registers
    always_ff @(posedge user_clk or negedge reset_n) begin
        if (!reset_n) begin
            data0_q <= '0;
            last0_q <= 1'b0;
            id0_q   <= '0;
            data1_q <= '0;
            last1_q <= 1'b0;
            id1_q   <= '0;
        end else begin
            data0_q <= data0_d;
            last0_q <= last0_d;
            id0_q   <= id0_d;
            data1_q <= data1_d;
            last1_q <= last1_d;
            id1_q   <= id1_d;
        end
    end

    assign bus.s_tready = s_tready_c;
    assign bus.m_tvalid = (cnt_q != 2'd0);
    assign bus.m_tdata  = data0_q;
    assign bus.m_tlast  = last0_q;
    assign bus.m_tid    = id0_q;
    assign busy         = (state_q == LOCKED);

endmodule

// File: tb/tb_rs_rr_arbiter.sv
// Self-checking bench for rs_rr_arbiter: vector table, corner sequences,
// and a scoreboard fed by accepted input beats.
module tb_rs_rr_arbiter;
    localparam int DW  = 32;
    localparam int NCH = 4;
    localparam int CW  = $clog2(NCH);

    logic user_clk = 1'b0;
    logic reset_n  = 1'b0;
    logic busy;

    always #5 user_clk = ~user_clk;

    rs_rr_arbiter_if #(.DATA_WIDTH(DW), .NUM_CH(NCH)) bus ();

    rs_rr_arbiter #(.DATA_WIDTH(DW), .NUM_CH(NCH)) dut (
        .user_clk (user_clk),
        .reset_n  (reset_n),
        .bus      (bus),
        .busy     (busy)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
        logic [CW-1:0] id;
    } beat_t;

    typedef struct {
        logic [NCH-1:0] v;
        logic [NCH-1:0] rdy;
    } vec_t;

    beat_t         sb[$];
    logic [CW-1:0] out_log[$];
    int            n_tests = 0;
    int            n_fail  = 0;
    bit            rnd_mode = 1'b0;
    int            out_cnt[NCH];
    bit            open_pkt = 1'b0;
    logic [CW-1:0] open_id;
    bit            hold = 1'b0;
    beat_t         held;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: bound expired or unexpected event", name);
    endtask

    task automatic tick();
        @(posedge user_clk);
        #1;
    endtask

    task automatic set_ch(input int i, input logic [DW-1:0] d, input logic l);
        bus.s_tdata[i*DW +: DW] = d;
        bus.s_tlast[i]          = l;
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && bus.m_tvalid; k++) tick();
        if (bus.m_tvalid) fail("drain_timeout");
    endtask

    // Monitor: record accepts, pop scoreboard on outputs, check hold/atomicity
    always @(negedge user_clk) begin
        beat_t got;
        beat_t exp;
        if (!reset_n) begin
            hold     = 1'b0;
            open_pkt = 1'b0;
        end else begin
            got = {bus.m_tdata, bus.m_tlast, bus.m_tid};
            if (hold) begin
                chk("hold_valid", 64'(bus.m_tvalid), 64'(1));
                chk("hold_beat", 64'(got), 64'(held));
            end
            hold = bus.m_tvalid && !bus.m_tready;
            held = got;
            for (int i = 0; i < NCH; i++) begin
                if (bus.s_tvalid[i] && bus.s_tready[i])
                    sb.push_back(beat_t'({bus.s_tdata[i*DW +: DW],
                                          bus.s_tlast[i], CW'(i)}));
            end
            if (bus.m_tvalid && bus.m_tready) begin
                out_log.push_back(bus.m_tid);
                if (sb.size() == 0) begin
                    fail("sb_underflow");
                end else begin
                    exp = sb.pop_front();
                    chk("sb_beat", 64'(got), 64'(exp));
                end
                if (open_pkt) chk("atomic_tid", 64'(bus.m_tid), 64'(open_id));
                open_pkt = !bus.m_tlast;
                open_id  = bus.m_tid;
                if (rnd_mode) begin
                    chk("chan_seq", 64'(bus.m_tdata[23:0]),
                        64'(out_cnt[bus.m_tid]));
                    out_cnt[bus.m_tid]++;
                end
            end
        end
    end

    vec_t           tbl[13];
    logic [NCH-1:0] s2v[5]   = '{4'b0111, 4'b0111, 4'b0111, 4'b0101, 4'b0001};
    logic [NCH-1:0] s2r[5]   = '{4'b0010, 4'b0010, 4'b0010, 4'b0100, 4'b0001};
    logic           s2b[5]   = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic           s2l[5]   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [NCH-1:0] s4v[7]   = '{4'b1001, 4'b0001, 4'b0001, 4'b0001,
                                 4'b0001, 4'b1001, 4'b0001};
    logic [NCH-1:0] s4r[7]   = '{4'b1000, 4'b1000, 4'b1000, 4'b1000,
                                 4'b1000, 4'b1000, 4'b0001};
    logic           s4b[7]   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    initial begin
        bit             prev_acc;
        logic [CW-1:0]  prev_ch;
        int             n;
        int             pk_left[NCH];
        int             len[NCH];
        int             bidx[NCH];
        int             seq[NCH];
        logic [NCH-1:0] acc;
        int             cyc;
        bit             more;

        tbl[0]  = '{4'b1111, 4'b0001};
        tbl[1]  = '{4'b1111, 4'b0010};
        tbl[2]  = '{4'b1111, 4'b0100};
        tbl[3]  = '{4'b1111, 4'b1000};
        tbl[4]  = '{4'b1111, 4'b0001};
        tbl[5]  = '{4'b1010, 4'b0010};
        tbl[6]  = '{4'b1010, 4'b1000};
        tbl[7]  = '{4'b0110, 4'b0010};
        tbl[8]  = '{4'b0110, 4'b0100};
        tbl[9]  = '{4'b0001, 4'b0001};
        tbl[10] = '{4'b0000, 4'b0000};
        tbl[11] = '{4'b1001, 4'b1000};
        tbl[12] = '{4'b0101, 4'b0001};

        bus.s_tvalid = '0;
        bus.s_tdata  = '0;
        bus.s_tlast  = '0;
        bus.m_tready = 1'b0;

        #12;
        chk("rst_mvalid", 64'(bus.m_tvalid), 64'(0));
        chk("rst_sready", 64'(bus.s_tready), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_mdata", 64'(bus.m_tdata), 64'(0));
        chk("rst_mtid", 64'(bus.m_tid), 64'(0));
        tick();
        reset_n = 1'b1;
        tick();

        // Round-robin table with single-beat packets and free-running sink
        bus.m_tready = 1'b1;
        bus.s_tlast  = '1;
        prev_acc     = 1'b0;
        prev_ch      = '0;
        for (int r = 0; r < 13; r++) begin
            bus.s_tvalid = tbl[r].v;
            for (int i = 0; i < NCH; i++)
                set_ch(i, 32'hA000_0000 | DW'(r << 4) | DW'(i), 1'b1);
            #1;
            chk("rr_ready", 64'(bus.s_tready), 64'(tbl[r].rdy));
            chk("rr_mvalid", 64'(bus.m_tvalid), 64'(prev_acc));
            if (prev_acc) chk("rr_mtid", 64'(bus.m_tid), 64'(prev_ch));
            prev_acc = |tbl[r].rdy;
            for (int i = 0; i < NCH; i++)
                if (tbl[r].rdy[i]) prev_ch = CW'(i);
            tick();
        end
        bus.s_tvalid = '0;
        drain();

        // Three-beat ch1 packet with ch0 and ch2 competing
        out_log.delete();
        for (int c = 0; c < 5; c++) begin
            bus.s_tvalid = s2v[c];
            set_ch(0, 32'hB000, 1'b1);
            set_ch(1, 32'hB100 + DW'(c), s2l[c]);
            set_ch(2, 32'hB200, 1'b1);
            #1;
            chk("pkt_ready", 64'(bus.s_tready), 64'(s2r[c]));
            chk("pkt_busy", 64'(busy), 64'(s2b[c]));
            tick();
        end
        bus.s_tvalid = '0;
        drain();
        chk("pkt_count", 64'(out_log.size()), 64'(5));
        if (out_log.size() == 5) begin
            chk("pkt_tid0", 64'(out_log[0]), 64'(1));
            chk("pkt_tid2", 64'(out_log[2]), 64'(1));
            chk("pkt_tid3", 64'(out_log[3]), 64'(2));
            chk("pkt_tid4", 64'(out_log[4]), 64'(0));
        end

        // Backpressure on continuous ch0 traffic
        out_log.delete();
        bus.m_tready = 1'b0;
        bus.s_tvalid = 4'b0001;
        n = 0;
        for (int c = 0; c < 5; c++) begin
            set_ch(0, 32'hC000 + DW'(n), 1'b1);
            #1;
            chk("bp_ready", 64'(bus.s_tready), 64'(c < 2 ? 4'b0001 : 4'b0000));
            if (bus.s_tready[0]) n++;
            tick();
        end
        chk("bp_accepts", 64'(n), 64'(2));
        chk("bp_head", 64'(bus.m_tdata), 64'(32'hC000));
        bus.s_tvalid = '0;
        bus.m_tready = 1'b1;
        drain();
        chk("bp_drained", 64'(out_log.size()), 64'(2));

        // Mid-packet bubble on ch3 while ch0 keeps requesting
        out_log.delete();
        for (int c = 0; c < 7; c++) begin
            bus.s_tvalid = s4v[c];
            set_ch(0, 32'hD000, 1'b1);
            set_ch(3, 32'hD300 + DW'(c), c == 5);
            #1;
            chk("bub_ready", 64'(bus.s_tready), 64'(s4r[c]));
            chk("bub_busy", 64'(busy), 64'(s4b[c]));
            tick();
        end
        bus.s_tvalid = '0;
        drain();
        chk("bub_count", 64'(out_log.size()), 64'(3));
        if (out_log.size() == 3) begin
            chk("bub_tid1", 64'(out_log[1]), 64'(3));
            chk("bub_tid2", 64'(out_log[2]), 64'(0));
        end

        // Asynchronous reset while locked with a full buffer
        bus.m_tready = 1'b0;
        bus.s_tvalid = 4'b0010;
        for (int c = 0; c < 2; c++) begin
            set_ch(1, 32'hE100 + DW'(c), 1'b0);
            #1;
            chk("ar_ready", 64'(bus.s_tready), 64'(4'b0010));
            tick();
        end
        #1;
        chk("ar_full", 64'(bus.s_tready), 64'(0));
        chk("ar_busy_pre", 64'(busy), 64'(1));
        reset_n      = 1'b0;
        bus.s_tvalid = '0;
        #1;
        chk("ar_mvalid", 64'(bus.m_tvalid), 64'(0));
        chk("ar_sready", 64'(bus.s_tready), 64'(0));
        chk("ar_busy", 64'(busy), 64'(0));
        sb.delete();
        tick();
        tick();
        reset_n      = 1'b1;
        bus.m_tready = 1'b1;
        bus.s_tvalid = 4'b1111;
        for (int i = 0; i < NCH; i++) set_ch(i, 32'hF000 + DW'(i), 1'b1);
        #1;
        chk("ar_prio", 64'(bus.s_tready), 64'(4'b0001));
        tick();
        bus.s_tvalid = '0;
        drain();

        // Random multi-beat traffic with random backpressure
        rnd_mode = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            out_cnt[i] = 0;
            pk_left[i] = 10;
            len[i]     = $urandom_range(1, 4);
            bidx[i]    = 0;
            seq[i]     = 0;
        end
        cyc  = 0;
        more = 1'b1;
        while (more && cyc < 4000) begin
            for (int i = 0; i < NCH; i++) begin
                bus.s_tvalid[i] = (pk_left[i] > 0) && ($urandom_range(0, 9) < 7);
                set_ch(i, {8'(i), 24'(seq[i])}, bidx[i] == len[i] - 1);
            end
            bus.m_tready = ($urandom_range(0, 3) != 0);
            #1;
            chk("rnd_onehot", 64'($onehot0(bus.s_tready)), 64'(1));
            acc = bus.s_tvalid & bus.s_tready;
            tick();
            more = 1'b0;
            for (int i = 0; i < NCH; i++) begin
                if (acc[i]) begin
                    seq[i]++;
                    bidx[i]++;
                    if (bidx[i] == len[i]) begin
                        bidx[i] = 0;
                        pk_left[i]--;
                        len[i] = $urandom_range(1, 4);
                    end
                end
                if (pk_left[i] > 0) more = 1'b1;
            end
            cyc++;
        end
        if (more) fail("rnd_timeout");
        bus.s_tvalid = '0;
        bus.m_tready = 1'b1;
        drain();
        tick();
        chk("rnd_sb_empty", 64'(sb.size()), 64'(0));
        for (int i = 0; i < NCH; i++)
            chk("rnd_chan_total", 64'(out_cnt[i]), 64'(seq[i]));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
